// File: rtl/bfcpu_pkg.sv
// Shared Brainfuck CPU definitions: opcode encodings and default datapath widths.
package bfcpu_pkg;

   localparam int D_WIDTH_DEF = 8;
   localparam int A_WIDTH_DEF = 12;

   // 0x00 is the ROM fill value, so running off the end of a program lands on it
   localparam logic [7:0] OP_HALT       = 8'h00;
   localparam logic [7:0] OP_INC        = 8'h2B;
   localparam logic [7:0] OP_DEC        = 8'h2D;
   localparam logic [7:0] OP_RIGHT      = 8'h3E;
   localparam logic [7:0] OP_LEFT       = 8'h3C;
   localparam logic [7:0] OP_OUT        = 8'h2E;
   localparam logic [7:0] OP_IN         = 8'h2C;
   localparam logic [7:0] OP_LOOP_BEGIN = 8'h5B;
   localparam logic [7:0] OP_LOOP_END   = 8'h5D;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Prefetch FIFO for the fetch unit: register-based storage, head read straight
// from storage, flush has priority over push/pop, pops on empty are dropped.
module instr_fetch_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rdPtr_q;
   logic [PW-1:0]    wrPtr_q;
   logic [PW:0]      count_q;
   logic             doPop;

   assign doPop   = pop_i & (count_q != '0);
   assign rdata_o = mem_q[rdPtr_q];
   assign count_o = count_q;

   // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wrPtr_q] <= wdata_i;
            wrPtr_q        <= wrPtr_q + PW'(1);
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + PW'(1);
         end
         count_q <= count_q + (PW+1)'(push_i) - (PW+1)'(doPop);
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives the ROM read port, absorbs its one-cycle read
// latency and buffers {pc, opcode} pairs for the decoder. Redirects flush all
// stale prefetches. Optional halt-on-OP_HALT behaviour: INSTR_FETCH_HALT_EN.
module instr_fetch
   import bfcpu_pkg::*;
#(
   parameter int D_WIDTH    = D_WIDTH_DEF,
   parameter int A_WIDTH    = A_WIDTH_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               rom_ce,
   output logic [A_WIDTH-1:0] rom_a,
   input  logic [D_WIDTH-1:0] rom_q,
   output logic               insn_valid,
   input  logic               insn_ready,
   output logic [D_WIDTH-1:0] insn_data,
   output logic [A_WIDTH-1:0] insn_pc,
   input  logic               redirect,
   input  logic [A_WIDTH-1:0] redirect_pc,
   output logic               halted
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [A_WIDTH-1:0]         fetchPc_q, fetchPc_d;
   logic [A_WIDTH-1:0]         pendPc_q, pendPc_d;
   logic                       pend_q, pend_d;
   logic [CW-1:0]              count;
   logic [CW:0]                occupancy;
   logic                       push, pop;
   logic                       haltGate, haltCapture;
   logic [A_WIDTH+D_WIDTH-1:0] headEntry;

   assign insn_valid = (count != '0);
   assign pop        = insn_valid & insn_ready;
   assign push       = pend_q & ~redirect;
   assign rom_a      = fetchPc_q;
   assign insn_pc    = headEntry[A_WIDTH+D_WIDTH-1:D_WIDTH];
   assign insn_data  = headEntry[D_WIDTH-1:0];

   // Entries held plus the read in flight, minus what leaves this cycle, must stay below depth
   assign occupancy = {1'b0, count} + (CW+1)'(pend_q) - (CW+1)'(pop);
   assign rom_ce    = rst_n & ~redirect & ~haltGate & (occupancy < (CW+1)'(FIFO_DEPTH));

`ifdef INSTR_FETCH_HALT_EN
   logic halted_q, halted_d;

   assign haltGate    = halted_q;
   assign haltCapture = push & (rom_q == D_WIDTH'(OP_HALT));
   assign halted      = halted_q;

   // Halt latches when a halt opcode is captured; only a redirect releases it
   always_comb begin
      halted_d = halted_q;
      if (redirect) begin
         halted_d = 1'b0;
      end else if (haltCapture) begin
         halted_d = 1'b1;
      end
   end

   // Halt flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= halted_d;
      end
   end
`else
   assign haltGate    = 1'b0;
   assign haltCapture = 1'b0;
   assign halted      = 1'b0;
`endif

   // Next fetch address and in-flight tracking; redirect wins over issue and capture
   always_comb begin
      fetchPc_d = fetchPc_q;
      pendPc_d  = pendPc_q;
      pend_d    = 1'b0;
      if (redirect) begin
         fetchPc_d = redirect_pc;
      end else begin
         if (rom_ce) begin
            fetchPc_d = fetchPc_q + A_WIDTH'(1);
            pendPc_d  = fetchPc_q;
            pend_d    = 1'b1;
         end
         // The read issued alongside a halt capture is thrown away
         if (haltCapture) begin
            pend_d = 1'b0;
         end
      end
   end

   // Fetch pointer and pending-read registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetchPc_q <= '0;
         pendPc_q  <= '0;
         pend_q    <= 1'b0;
      end else begin
         fetchPc_q <= fetchPc_d;
         pendPc_q  <= pendPc_d;
         pend_q    <= pend_d;
      end
   end

   instr_fetch_fifo #(
      .WIDTH (A_WIDTH + D_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) uFifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redirect),
      .wdata_i ({pendPc_q, rom_q}),
      .rdata_o (headEntry),
      .count_o (count)
   );

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the reading end of the instruction ROM port. Drives the ROM's chip-enable and address, absorbs the ROM's one-cycle registered read latency, and buffers fetched opcodes with their addresses in a small prefetch FIFO. Presents them to the decoder over a valid/ready handshake. Accepts redirect requests from the loop (`[`/`]`) logic and flushes stale prefetches.

## Interface
- `D_WIDTH`, 8: opcode width; matches the ROM data width.
- `A_WIDTH`, 12: instruction address width; matches the ROM address width.
- `FIFO_DEPTH`, 4: prefetch entries; power of two, ≥2.

- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `rom_ce`  out  1: ROM read enable.
- `rom_a`  out  A_WIDTH: ROM read address.
- `rom_q`  in  D_WIDTH: ROM read data, valid the cycle after `rom_ce`.
- `insn_valid`  out  1: FIFO head holds an instruction.
- `insn_ready`  in  1: decoder accepts the head this cycle.
- `insn_data`  out  D_WIDTH: head opcode.
- `insn_pc`  out  A_WIDTH: head opcode address.
- `redirect`  in  1: one-cycle pulse; restart fetch at `redirect_pc`.
- `redirect_pc`  in  A_WIDTH: redirect target.
- `halted`  out  1: fetch stopped on a halt opcode. Tied 0 without the macro.

## Operation
- **State.**
  - `fetch_pc`: next address to issue.
  - `pend` and `pend_pc`: a read is in flight, and its address.
  - FIFO of `{pc, data}` entries with a count.
  - `halted` flag.
- **Issue.**
  - `rom_ce = rst_n & ~redirect & ~halted & ((count + pend − pop) < FIFO_DEPTH)`, where `pop = insn_valid & insn_ready`.
  - `rom_a = fetch_pc`.
  - On issue: `fetch_pc <= fetch_pc + 1`, modulo 2^A_WIDTH. After 0xFFF the next address is 0x000.
  - On issue: `pend <= 1` and `pend_pc <= fetch_pc`. Otherwise `pend <= 0`.
- **Capture.** When `pend` is 1 in a cycle with no redirect, `{pend_pc, rom_q}` is pushed into the FIFO at the end of that cycle.
- **Consume.** A transfer occurs when `insn_valid & insn_ready`; the head is popped at the end of that cycle.
- **Simultaneous push and pop** is legal. The count is unchanged.
- **Pop on empty** is ignored.
- **Redirect** in cycle N takes effect at the end of cycle N, and overrides push, pop and issue in that cycle:
  - FIFO emptied;
  - `pend` cleared, so the in-flight read is discarded;
  - `fetch_pc <= redirect_pc`;
  - `halted` cleared.
  - A head shown in cycle N with `insn_ready` high counts as consumed by the decoder but is still flushed.
- **Issue gating.** The FIFO can never overflow.
- **Reset values:**
  - `rom_ce` 0 (combinational with `rst_n`);
  - `rom_a` 0;
  - `insn_valid` 0;
  - `insn_data` 0 and `insn_pc` 0 (FIFO storage reset to 0);
  - `halted` 0;
  - `fetch_pc` 0, `pend` 0, count 0.
- **Reset mid-operation** discards all state immediately. No partial transfer.

## Timing
- **From reset.** Reset deasserts before cycle 0.
  - Cycle 0: `rom_ce=1`, `rom_a=0`.
  - Cycle 1: `rom_q` = mem[0].
  - Cycle 2: `insn_valid=1`, `insn_pc=0`.
- **Redirect latency.** Redirect in cycle N gives:
  - `insn_valid=0` in cycle N+1;
  - issue of `redirect_pc` in cycle N+1;
  - the first new head valid in cycle N+3.
- **Throughput.** Sustained 1 instruction/cycle with `insn_ready` held high, for `FIFO_DEPTH` ≥ 2.
- **Output paths.** `insn_data` and `insn_pc` are registered (FIFO head). `rom_ce` is combinational from state and `redirect`/`insn_ready`. `rom_a` is registered.

## Configuration
- **Macro:** `INSTR_FETCH_HALT_EN`.
- **Defined:**
  - When a captured `rom_q` equals `OP_HALT` (0x00, the ROM fill value), the entry is still pushed so the decoder sees it.
  - `halted <= 1` at the end of that cycle.
  - The read issued in that same cycle is discarded: `pend` is cleared next cycle and no push occurs.
  - No further issue until a redirect or reset.
- **Undefined:** 0x00 is an ordinary opcode, fetch never stops, and `halted` is constant 0.

## Structure
- **Shared package `bfcpu_pkg`:**
  - `OP_HALT`;
  - the Brainfuck opcode constants;
  - default `D_WIDTH`/`A_WIDTH`.
- **Sub-module `instr_fetch_fifo`:**
  - synchronous FIFO of width `A_WIDTH + D_WIDTH`, depth `FIFO_DEPTH`;
  - push, pop and flush inputs;
  - count output;
  - `rst_n` reset.

## Test plan
- **Cold start.** ROM = 0x2B, 0x2D, 0x3E…; `insn_ready=1` after reset.
  - Required: pc 0,1,2,… at cycles 2,3,4,….
  - Required: `rom_ce` high every cycle.
- **Backpressure.** `insn_ready=0` for 10 cycles, then 1.
  - Required: `rom_ce` drops after 4 entries plus 0 in flight.
  - Required: no entry lost or duplicated; pc order continuous.
- **Redirect mid-stream.** Redirect to 0x100 at cycle 7 with `insn_ready` high.
  - Required: `insn_valid=0` at cycle 8.
  - Required: next head is pc 0x100 at cycle 10.
  - Required: no pre-redirect pc appears afterwards.
- **Wrap.** Redirect to 0xFFE.
  - Required: pcs 0xFFE, 0xFFF, 0x000, 0x001.
- **Halt (macro defined).** 0x00 at address 5.
  - Required: pc 5 delivered with data 0x00.
  - Required: `halted=1` afterwards, `rom_ce` stays 0, no pc 6.
  - Required: a redirect to 0 clears `halted` and restarts.
  - Macro undefined: pc 6 follows normally.
- **Async reset mid-run.** Assert `rst_n=0` mid-cycle with the FIFO holding 3 entries.
  - Required: `insn_valid` and `rom_ce` fall immediately.
  - Required: after release, fetch restarts at pc 0.
